// File: rtl/rob_retire_if.sv
// rtl/rob_retire_if.sv - ROB, free-list, RRF and flush signals of the retire unit
interface rob_retire_if #(
  parameter int SS        = 2,
  parameter int ROB_DEPTH = 16,
  parameter int PREG_W    = 6,
  parameter int AREG_W    = 5
);
  localparam int CNT_W = $clog2(ROB_DEPTH) + 1;
  localparam int POP_W = $clog2(SS) + 1;

  logic [CNT_W-1:0]             rob_count;
  logic [SS-1:0]                rob_done;
  logic [SS-1:0]                rob_mispred;
  logic [SS-1:0][AREG_W-1:0]    rob_areg;
  logic [SS-1:0][PREG_W-1:0]    rob_preg_new;
  logic [SS-1:0][PREG_W-1:0]    rob_preg_old;
  logic [SS-1:0][31:0]          rob_target;
  logic                         rob_pop;
  logic [POP_W-1:0]             rob_pop_cnt;
  logic [CNT_W-1:0]             fl_space;
  logic                         fl_push;
  logic [SS-1:0][PREG_W-1:0]    fl_preg;
  logic [POP_W-1:0]             fl_push_cnt;
  logic [SS-1:0]                rrf_we;
  logic [SS-1:0][AREG_W-1:0]    rrf_areg;
  logic [SS-1:0][PREG_W-1:0]    rrf_preg;
  logic                         flush;
  logic [31:0]                  flush_pc;
  logic [31:0]                  retired_total;

  modport master (
    input  rob_count, rob_done, rob_mispred, rob_areg, rob_preg_new, rob_preg_old,
           rob_target, fl_space,
    output rob_pop, rob_pop_cnt, fl_push, fl_preg, fl_push_cnt, rrf_we, rrf_areg,
           rrf_preg, flush, flush_pc, retired_total
  );

  modport slave (
    output rob_count, rob_done, rob_mispred, rob_areg, rob_preg_new, rob_preg_old,
           rob_target, fl_space,
    input  rob_pop, rob_pop_cnt, fl_push, fl_preg, fl_push_cnt, rrf_we, rrf_areg,
           rrf_preg, flush, flush_pc, retired_total
  );
endinterface

// File: rtl/rob_retire_unit.sv
// rtl/rob_retire_unit.sv - in-order ROB retirement with RRF update, free-list return and flush
module rob_retire_unit #(
  parameter int SS        = 2,
  parameter int ROB_DEPTH = 16,
  parameter int PREG_W    = 6,
  parameter int AREG_W    = 5
) (
  input logic         clk,
  input logic         rst_n,
  rob_retire_if.master bus
);
  localparam int CNT_W = $clog2(ROB_DEPTH) + 1;
  localparam int POP_W = $clog2(SS) + 1;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;
  state_t state;

  logic [POP_W-1:0]          n;
  logic                      stop;
  logic                      mis_hit;
  logic [31:0]               mis_pc;
  logic [SS-1:0]             free_c;
  logic [SS-1:0][PREG_W-1:0] fl_preg_c;
  logic [POP_W-1:0]          fl_cnt_c;

  // Oldest contiguous run of done entries, cut just after a mispredict.
  // Backpressure is all-or-nothing: no partial retire when the free list is short.
  always_comb begin
    n       = '0;
    stop    = 1'b0;
    mis_hit = 1'b0;
    mis_pc  = '0;
    for (int i = 0; i < SS; i++) begin
      if (!stop && (CNT_W'(i) < bus.rob_count) && bus.rob_done[i]) begin
        n = POP_W'(i + 1);
        if (bus.rob_mispred[i]) begin
          stop    = 1'b1;
          mis_hit = 1'b1;
          mis_pc  = bus.rob_target[i];
        end
      end else begin
        stop = 1'b1;
      end
    end
    if (state != RUN || bus.fl_space < CNT_W'(n)) begin
      n       = '0;
      mis_hit = 1'b0;
    end
  end

  // Entries writing arch reg 0 neither update the RRF nor free a register.
  always_comb begin
    free_c    = '0;
    fl_preg_c = '0;
    fl_cnt_c  = '0;
    for (int i = 0; i < SS; i++) begin
      free_c[i] = (POP_W'(i) < n) && (bus.rob_areg[i] != '0);
      for (int j = 0; j < SS; j++) begin
        if (free_c[i] && fl_cnt_c == POP_W'(j)) fl_preg_c[j] = bus.rob_preg_old[i];
      end
      if (free_c[i]) fl_cnt_c = fl_cnt_c + POP_W'(1);
    end
  end

  assign bus.rob_pop     = (n != '0);
  assign bus.rob_pop_cnt = n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= RUN;
      bus.rrf_we        <= '0;
      bus.rrf_areg      <= '0;
      bus.rrf_preg      <= '0;
      bus.fl_push       <= 1'b0;
      bus.fl_preg       <= '0;
      bus.fl_push_cnt   <= '0;
      bus.flush         <= 1'b0;
      bus.flush_pc      <= '0;
      bus.retired_total <= '0;
    end else begin
      bus.rrf_we        <= free_c;
      bus.rrf_areg      <= bus.rob_areg;
      bus.rrf_preg      <= bus.rob_preg_new;
      bus.fl_preg       <= fl_preg_c;
      bus.fl_push_cnt   <= fl_cnt_c;
      bus.fl_push       <= (fl_cnt_c != '0);
      bus.retired_total <= bus.retired_total + 32'(n);
      bus.flush         <= 1'b0;
      case (state)
        RUN: begin
          if (mis_hit) begin
            state        <= FLUSH;
            bus.flush    <= 1'b1;
            bus.flush_pc <= mis_pc;
          end
        end
        FLUSH:   state <= DRAIN;
        DRAIN:   if (bus.rob_count == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule
